// File: rtl/joy_db9md_pkg.sv
// Shared constants for the DB9 Mega Drive pad scanner: button bit positions,
// scanner FSM state codes and the select steps on which pad lines are sampled.
package joy_db9md_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;

    localparam logic [1:0] ST_GAP    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [2:0] STEP_BASE  = 3'd0;
    localparam logic [2:0] STEP_MDID  = 3'd1;
    localparam logic [2:0] STEP_SIXID = 3'd5;
    localparam logic [2:0] STEP_EXT   = 3'd6;

endpackage

// File: rtl/joy_db9md_capture.sv
// Capture bank for one port scan: turns the sampled active-low pad lines of the
// 8 select steps into the active-high 12-bit button word plus pad-type flags.
module joy_db9md_capture
    import joy_db9md_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sample_i,
    input  logic [2:0]  step_i,
    input  logic [5:0]  joy_i,
    output logic [11:0] word_o,
    output logic        pad_md_o,
    output logic        six_o
);

    logic [11:0] word_q;
    logic        pad_md_q;
    logic        six_q;
    logic        md_s;

    // L and R can only both read low while select is low on a Mega Drive pad
    assign md_s = (joy_i[3:2] == 2'b00);

    // Per-step sampling; every field is rewritten on each scan so no clear is needed
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_q   <= 12'h000;
            pad_md_q <= 1'b0;
            six_q    <= 1'b0;
        end else if (sample_i) begin
            case (step_i)
                STEP_BASE: begin
                    word_q[BTN_U] <= ~joy_i[0];
                    word_q[BTN_D] <= ~joy_i[1];
                    word_q[BTN_L] <= ~joy_i[2];
                    word_q[BTN_R] <= ~joy_i[3];
                    word_q[BTN_B] <= ~joy_i[4];
                    word_q[BTN_C] <= ~joy_i[5];
                end
                STEP_MDID: begin
                    pad_md_q          <= md_s;
                    word_q[BTN_A]     <= md_s & ~joy_i[4];
                    word_q[BTN_START] <= md_s & ~joy_i[5];
                end
                STEP_SIXID: begin
                    six_q <= pad_md_q & (joy_i[3:0] == 4'b0000);
                end
                STEP_EXT: begin
                    word_q[BTN_Z]    <= six_q & ~joy_i[0];
                    word_q[BTN_Y]    <= six_q & ~joy_i[1];
                    word_q[BTN_X]    <= six_q & ~joy_i[2];
                    word_q[BTN_MODE] <= six_q & ~joy_i[3];
                end
                default: begin
                    word_q <= word_q;
                end
            endcase
        end else begin
            word_q <= word_q;
        end
    end

    assign word_o   = word_q;
    assign pad_md_o = pad_md_q;
    assign six_o    = six_q;

endmodule

// File: rtl/joy_db9md_scan.sv
// Scans 1 or 2 DB9 Mega Drive / Atari ports through an external splitter with
// the 8-phase select protocol. Optional JOY_DB9MD_DEBOUNCE_EN: two-frame match filter.
module joy_db9md_scan
    import joy_db9md_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int STEP_CYC  = 256,
    parameter int GAP_CYC   = 48000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [11:0] joystick_0,
    output logic [11:0] joystick_1,
    output logic [1:0]  present,
    output logic [1:0]  six_btn,
    output logic        frame_done
);

    localparam int CNT_MAX = (STEP_CYC > GAP_CYC) ? STEP_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic          LAST_PORT = (NUM_PORTS > 1) ? 1'b1 : 1'b0;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          port_q, port_d;
    logic          mdsel_q, mdsel_d;
    logic          split_q, split_d;
    logic          done_q, done_d;
    logic [11:0]   joy0_q, joy1_q;
    logic [1:0]    present_q, six_q;
    logic          sample_s, commit_s, accept_s;
    logic [11:0]   word_s;
    logic          pad_md_s, six_s;
    logic [13:0]   cap_s;

    // Scan sequencing: GAP -> (SETTLE -> 8 steps -> COMMIT) per port -> GAP
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_ONE;
        step_d   = step_q;
        port_d   = port_q;
        split_d  = split_q;
        sample_s = 1'b0;
        commit_s = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ZERO;
                    port_d  = 1'b0;
                    split_d = 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == STEP_LAST) begin
                    state_d = ST_STEP;
                    cnt_d   = CNT_ZERO;
                    step_d  = 3'd0;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_STEP: begin
                if (cnt_q == STEP_LAST) begin
                    sample_s = 1'b1;
                    cnt_d    = CNT_ZERO;
                    if (step_q == 3'd7) begin
                        state_d = ST_COMMIT;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_COMMIT: begin
                commit_s = 1'b1;
                cnt_d    = CNT_ZERO;
                if (port_q == LAST_PORT) begin
                    split_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    port_d  = ~port_q;
                    split_d = ~split_q;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = CNT_ZERO;
            end
        endcase
        // Select follows the next state so it is already valid in a step's first cycle
        mdsel_d = ~((state_d == ST_STEP) && step_d[0]);
    end

    joy_db9md_capture u_capture (
        .clk_i    (clk),
        .reset_i  (reset),
        .sample_i (sample_s),
        .step_i   (step_q),
        .joy_i    (joy_in),
        .word_o   (word_s),
        .pad_md_o (pad_md_s),
        .six_o    (six_s)
    );

    assign cap_s = {six_s, pad_md_s, word_s};

`ifdef JOY_DB9MD_DEBOUNCE_EN
    logic [13:0] shadow_q [2];

    assign accept_s = (cap_s == shadow_q[port_q]);

    // Previous-frame capture per port; refreshed on every commit, accepted or not
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q[0] <= 14'h0000;
            shadow_q[1] <= 14'h0000;
        end else if (commit_s) begin
            shadow_q[port_q] <= cap_s;
        end else begin
            shadow_q[port_q] <= shadow_q[port_q];
        end
    end
`else
    assign accept_s = 1'b1;
`endif

    // FSM registers, select lines and atomically committed per-port results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GAP;
            cnt_q     <= CNT_ZERO;
            step_q    <= 3'd0;
            port_q    <= 1'b0;
            mdsel_q   <= 1'b1;
            split_q   <= 1'b1;
            done_q    <= 1'b0;
            joy0_q    <= 12'h000;
            joy1_q    <= 12'h000;
            present_q <= 2'b00;
            six_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            port_q  <= port_d;
            mdsel_q <= mdsel_d;
            split_q <= split_d;
            done_q  <= done_d;
            if (commit_s && accept_s) begin
                if (port_q == 1'b0) begin
                    joy0_q       <= word_s;
                    present_q[0] <= pad_md_s;
                    six_q[0]     <= six_s;
                end else begin
                    joy1_q       <= word_s;
                    present_q[1] <= pad_md_s;
                    six_q[1]     <= six_s;
                end
            end
        end
    end

    assign joy_mdsel  = mdsel_q;
    assign joy_split  = split_q;
    assign joystick_0 = joy0_q;
    assign joystick_1 = joy1_q;
    assign present    = present_q;
    assign six_btn    = six_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_joy_db9md_scan.sv
// Bench for joy_db9md_scan (STEP_CYC=4, GAP_CYC=32, NUM_PORTS=2): pad models on
// both ports, a frame-position reference model checked every cycle, plus literals.
module tb_joy_db9md_scan;

    localparam int STEP     = 4;
    localparam int GAP      = 32;
    localparam int PORT_LEN = 9 * STEP + 1;
    localparam int FRAME    = GAP + 2 * PORT_LEN;

    localparam logic [1:0] T_NONE  = 2'd0;
    localparam logic [1:0] T_ATARI = 2'd1;
    localparam logic [1:0] T_MD3   = 2'd2;
    localparam logic [1:0] T_MD6   = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel, joy_split, frame_done;
    logic [11:0] joystick_0, joystick_1;
    logic [1:0]  present, six_btn;

    logic [1:0]  ptype [2];
    logic [11:0] pbtn [2];
    int          n = 0;
    logic        mdsel_prev = 1'b1;
    logic        split_prev = 1'b1;

    int          t = 0;
    logic        chk_en = 1'b0;
    logic [11:0] exp_j0 = 12'h000, exp_j1 = 12'h000;
    logic [1:0]  exp_pres = 2'b00, exp_six = 2'b00;
    int          tests = 0;
    int          fails = 0;

    joy_db9md_scan #(.NUM_PORTS(2), .STEP_CYC(STEP), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_in     (joy_in),
        .joy_mdsel  (joy_mdsel),
        .joy_split  (joy_split),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .present    (present),
        .six_btn    (six_btn),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pad line levels (active low) given pad type, pressed buttons, select and select-fall count
    function automatic logic [5:0] pad_lines(input logic [1:0] ty, input logic [11:0] b,
                                             input logic sel, input int cnt);
        logic [5:0] act;
        act = 6'b000000;
        case (ty)
            T_ATARI: act = {b[5], b[4], b[0], b[1], b[2], b[3]};
            T_MD3, T_MD6: begin
                if (ty == T_MD6 && cnt == 3 && sel)        act = {b[5], b[4], b[11], b[10], b[9], b[8]};
                else if (ty == T_MD6 && cnt == 3 && !sel)  act = {b[7], b[6], 4'b1111};
                else if (ty == T_MD6 && cnt == 4 && !sel)  act = {b[7], b[6], 4'b0000};
                else if (sel)                              act = {b[5], b[4], b[0], b[1], b[2], b[3]};
                else                                       act = {b[7], b[6], 2'b11, b[2], b[3]};
            end
            default: act = 6'b000000;
        endcase
        return ~act;
    endfunction

    // What a port reports for a pad: {six, present, buttons}
    function automatic logic [13:0] model_cap(input logic [1:0] ty, input logic [11:0] b);
        case (ty)
            T_MD6:   return {2'b11, b};
            T_MD3:   return {2'b01, b & 12'h0FF};
            T_ATARI: return {2'b00, b & 12'h03F};
            default: return 14'h0000;
        endcase
    endfunction

    function automatic logic exp_mdsel_f(input int tt);
        int pos, r;
        pos = tt % FRAME;
        if (pos < GAP) return 1'b1;
        r = (pos - GAP) % PORT_LEN;
        if (r < STEP || r >= 9 * STEP) return 1'b1;
        return (((r - STEP) / STEP) % 2) == 0;
    endfunction

    function automatic logic exp_split_f(input int tt);
        return (tt % FRAME) < (GAP + PORT_LEN);
    endfunction

    function automatic logic exp_done_f(input int tt);
        return (tt > 0) && ((tt % FRAME) == 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at t=%0d: got 'h%0h, expected 'h%0h", nm, t, act, exp);
        end
    endtask

    assign joy_in = joy_split ? pad_lines(ptype[0], pbtn[0], joy_mdsel, n)
                              : pad_lines(ptype[1], pbtn[1], joy_mdsel, n);

    // Pad-side select-fall counter, restarted whenever the splitter changes port
    always @(negedge clk) begin
        if (reset || (joy_split != split_prev)) n <= 0;
        else if (mdsel_prev && !joy_mdsel)      n <= n + 1;
        mdsel_prev <= joy_mdsel;
        split_prev <= joy_split;
    end

    // Reference model: frame position and committed results
    always @(posedge clk) begin
        if (reset) begin
            t        <= 0;
            exp_j0   <= 12'h000;
            exp_j1   <= 12'h000;
            exp_pres <= 2'b00;
            exp_six  <= 2'b00;
        end else begin
            t <= t + 1;
`ifdef JOY_DB9MD_DEBOUNCE_EN
            if (((t + 1) % FRAME) == GAP + PORT_LEN) begin
                if (model_cap(ptype[0], pbtn[0]) == prev_cap[0])
                    {exp_six[0], exp_pres[0], exp_j0} <= model_cap(ptype[0], pbtn[0]);
                prev_cap[0] <= model_cap(ptype[0], pbtn[0]);
            end
            if (((t + 1) % FRAME) == 0) begin
                if (model_cap(ptype[1], pbtn[1]) == prev_cap[1])
                    {exp_six[1], exp_pres[1], exp_j1} <= model_cap(ptype[1], pbtn[1]);
                prev_cap[1] <= model_cap(ptype[1], pbtn[1]);
            end
`else
            if (((t + 1) % FRAME) == GAP + PORT_LEN)
                {exp_six[0], exp_pres[0], exp_j0} <= model_cap(ptype[0], pbtn[0]);
            if (((t + 1) % FRAME) == 0)
                {exp_six[1], exp_pres[1], exp_j1} <= model_cap(ptype[1], pbtn[1]);
`endif
        end
    end

`ifdef JOY_DB9MD_DEBOUNCE_EN
    logic [13:0] prev_cap [2];
    always @(posedge clk) begin
        if (reset) begin
            prev_cap[0] <= 14'h0000;
            prev_cap[1] <= 14'h0000;
        end
    end
`endif

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdsel", joy_mdsel, exp_mdsel_f(t));
            check("split", joy_split, exp_split_f(t));
            check("frame_done", frame_done, exp_done_f(t));
            check("joystick_0", joystick_0, exp_j0);
            check("joystick_1", joystick_1, exp_j1);
            check("present", present, exp_pres);
            check("six_btn", six_btn, exp_six);
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        if (k == 3 * FRAME) check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic settle();
        wait_done();
`ifdef JOY_DB9MD_DEBOUNCE_EN
        wait_done();
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int per, tog, splow, cnt;
        logic last;
        ptype[0] = T_MD6;  pbtn[0] = 12'h448;
        ptype[1] = T_NONE; pbtn[1] = 12'h000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // 6-button pad on port 0, nothing on port 1
        settle();
        check("md6_joy0", joystick_0, 12'h448);
        check("md6_present", present, 2'b01);
        check("md6_six", six_btn, 2'b01);
        check("unplugged_joy1", joystick_1, 12'h000);

        // 3-button pad on port 1
        ptype[1] = T_MD3; pbtn[1] = 12'h0A0;
        settle();
        check("md3_joy1", joystick_1, 12'h0A0);
        check("md3_present", present, 2'b11);
        check("md3_six", six_btn, 2'b01);
        check("md3_hi_zero", joystick_1[11:8], 4'h0);

        // Atari stick on port 0
        ptype[0] = T_ATARI; pbtn[0] = 12'h011;
        settle();
        check("atari_joy0", joystick_0, 12'h011);
        check("atari_present0", present[0], 1'b0);
        check("atari_six0", six_btn[0], 1'b0);

        // One full frame of timing
        per = 0; tog = 0; splow = 0; last = joy_mdsel;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            per++;
            if (joy_mdsel != last) tog++;
            last = joy_mdsel;
            if (!joy_split) splow++;
            if (frame_done) break;
        end
        check("frame_period", per, 106);
        check("mdsel_toggles", tog, 16);
        check("split_low_cycles", splow, 37);

        // Reset for 3 cycles in the middle of step 3 of port 0
        repeat (49) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mdsel", joy_mdsel, 1'b1);
        check("rst_split", joy_split, 1'b1);
        check("rst_joy0", joystick_0, 12'h000);
        check("rst_joy1", joystick_1, 12'h000);
        check("rst_present", present, 2'b00);
        check("rst_six", six_btn, 2'b00);
        check("rst_done", frame_done, 1'b0);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (!joy_mdsel) break;
        end
        check("first_mdsel_fall", cnt, 40);

        // Single-frame glitch, then a button held for two frames
        wait_done();
        ptype[0] = T_MD6; pbtn[0] = 12'h000;
        settle();
        pbtn[0] = 12'h040;
        wait_done();
`ifdef JOY_DB9MD_DEBOUNCE_EN
        check("glitch_filtered", joystick_0, 12'h000);
`else
        check("glitch_pass", joystick_0, 12'h040);
`endif
        pbtn[0] = 12'h000;
        wait_done();
        check("glitch_gone", joystick_0, 12'h000);
        pbtn[0] = 12'h800;
        wait_done();
`ifdef JOY_DB9MD_DEBOUNCE_EN
        check("hold_frame1", joystick_0, 12'h000);
`else
        check("hold_frame1", joystick_0, 12'h800);
`endif
        wait_done();
        check("hold_frame2", joystick_0, 12'h800);
        check("hold_six", six_btn[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/joy_db9md_scan.md
Name: joy_db9md_scan

Overview:
- Parametrised successor to the single-pair DB9 Mega Drive pad reader used on the SNAC user port.
- Time-multiplexes 1 or 2 ports through an external splitter (joy_split) and runs the full 8-phase 6-button select protocol on each port (joy_mdsel).
- Detects per port whether a pad is connected and whether it is 3- or 6-button; plain Atari sticks are also handled.
- Sits between the USER_IN/USER_OUT pins and the core joystick mux, feeding joy_A/joy_B and hps_io joy_raw.

Parameters:
- NUM_PORTS, 2, ports scanned (1 or 2); 1 holds joy_split high permanently.
- STEP_CYC, 256, clk cycles per select half-phase (about 12 us at 21.48 MHz); minimum 4.
- GAP_CYC, 48000, idle cycles with mdsel high after each full scan (must exceed 1.5 ms); minimum 8.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high reset
- joy_in  in  6  pad lines, active low: [0]U [1]D [2]L [3]R [4]B/A [5]C/Start
- joy_mdsel  out  1  Mega Drive select line to both ports
- joy_split  out  1  splitter select; 1 = port 0, 0 = port 1
- joystick_0  out  12  port 0 buttons, active high: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Z [9]Y [10]X [11]Mode
- joystick_1  out  12  port 1, same layout; held 0 when NUM_PORTS=1
- present  out  2  per port: MD pad detected
- six_btn  out  2  per port: 6-button pad detected
- frame_done  out  1  one-cycle pulse after the last port commits

Behaviour:
- Reset (synchronous, active-high, one clk):
  - joy_mdsel=1, joy_split=1.
  - joystick_0/1=0, present=0, six_btn=0, frame_done=0.
  - FSM enters GAP with counter cleared, so a full GAP_CYC elapses before the first toggle.
  - Reset mid-scan discards all partial captures; no commit occurs.
- FSM states:
  - GAP: mdsel=1 for GAP_CYC cycles, then go to SETTLE with port=0, split=1.
  - SETTLE: mdsel=1 for STEP_CYC cycles (splitter settle), then go to STEP with step=0.
  - STEP: step 0..7, each lasting STEP_CYC cycles; mdsel = 1 on even steps, 0 on odd steps.
    - joy_in is sampled only on the last cycle of each step (mdsel has been stable for STEP_CYC-1 cycles).
    - After step 7 of port p, go to COMMIT.
  - COMMIT: one cycle.
    - Updates joystick_p, present[p] and six_btn[p] atomically.
    - If p < NUM_PORTS-1: split toggles, port increments, go to SETTLE.
    - Otherwise: split returns to 1, frame_done=1, go to GAP.
- Capture per step (inputs inverted to active high):
  - step0 (mdsel=1): U, D, L, R, B, C.
  - step1 (mdsel=0): pad_md = L and R both low. If pad_md, capture A = ~joy_in[4] and Start = ~joy_in[5].
  - step5 (mdsel=0): six = pad_md and U, D, L, R all low.
  - step6 (mdsel=1): if six, Z = ~joy_in[0], Y = ~joy_in[1], X = ~joy_in[2], Mode = ~joy_in[3].
  - Steps 2, 3, 4 and 7: toggled only, nothing sampled.
- Commit rules:
  - Non-MD (Atari) stick: A, Start, Z, Y, X, Mode are 0; present=0; directions and B/C come from step0.
  - 3-button MD pad: bits [11:8] are 0.
- Frame period = GAP_CYC + NUM_PORTS*(9*STEP_CYC+1) cycles.
- Counters are sized with $clog2 of the larger of STEP_CYC and GAP_CYC; they never wrap mid-state.
- Outputs change only in COMMIT; they are stable for a full frame otherwise.

Optional Feature:
- Macro: JOY_DB9MD_DEBOUNCE_EN.
- When defined: the commit for port p is accepted only if its capture equals the previous frame's capture for that port. This adds a per-port 14-bit shadow register (12 buttons, present, six). Output latency becomes 2 frames, and a single-frame glitch never reaches the outputs.
- When undefined: every capture commits directly (1-frame latency) and no shadow registers exist.

Decomposition:
- Package joy_db9md_pkg:
  - Bit-index constants for the 12-bit button word (BTN_R .. BTN_MODE).
  - FSM state enum {GAP, SETTLE, STEP, COMMIT}.
  - Step constants for the capture steps 0, 1, 5, 6.
- Sub-module joy_db9md_capture:
  - Per-port capture register bank.
  - Inputs: step index, sample strobe, joy_in.
  - Outputs: assembled 12-bit word, pad_md, six.
  - Instantiated once, with the result steered by the port index.

Test Plan (STEP_CYC=4, GAP_CYC=32, NUM_PORTS=2):
- Reset held 3 cycles mid-STEP 3 -> next cycle mdsel=1, split=1, all outputs 0; first mdsel falling edge exactly 32+4+4 cycles after reset deasserts.
- Port 0 6-button model (Up+A+X pressed), port 1 unplugged (all lines high) -> after frame_done: joystick_0=12'h448, present=2'b01, six_btn=2'b01, joystick_1=0.
- Port 1 3-button model (Start+C pressed) -> joystick_1=12'h0A0, present[1]=1, six_btn[1]=0, bits [11:8]=0.
- Atari stick on port 0 (Right+B, L/R high on step1) -> joystick_0=12'h011, present[0]=0.
- Timing check -> mdsel toggles 8 times per port; inter-frame period equals 32+2*37 = 106 cycles; split low only between port 0 and port 1 COMMIT pulses.
- With JOY_DB9MD_DEBOUNCE_EN: a button asserted for exactly one frame -> no output change; held two frames -> appears at the 2nd COMMIT.
